// File: rtl/cg_pkg.sv
// cg_pkg: shared state encoding and default parameters for the clock-gating controller.
package cg_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } cg_state_e;

    localparam int IDLE_CYCLES_DEF = 8;
    localparam int WAKE_CYCLES_DEF = 2;
    localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/cg_latch_lo.sv
// cg_latch_lo: low-transparent enable latch with async set on reset, plus the gating AND.
module cg_latch_lo (
    input  logic i_ck,
    input  logic i_rn,
    input  logic i_d,
    output logic o_gck
);

    logic r_en_lat;

    // Opaque while the clock is high, so the enable only changes during the low phase.
    always_latch begin
        if (!i_rn)
            r_en_lat <= 1'b1;
        else if (!i_ck)
            r_en_lat <= i_d;
    end

    assign o_gck = i_ck & r_en_lat;

endmodule

// File: rtl/cg_ctrl_lo.sv
// cg_ctrl_lo: idle-driven clock-gating controller with sleep request/ok handshake.
// Defining CG_TEST_EN adds a TE input that forces the gated clock on for scan.
module cg_ctrl_lo
    import cg_pkg::*;
#(
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
    parameter int WAKE_CYCLES = WAKE_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       CK,
    input  logic       RN,
`ifdef CG_TEST_EN
    input  logic       TE,
`endif
    input  logic       busy_i,
    input  logic       wake_req,
    input  logic       sleep_ok_i,
    output logic       sleep_req_o,
    output logic       wake_ack,
    output logic       gated_o,
    output logic [1:0] state_o,
    output logic       GCK
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    cg_state_e        r_state, w_nstate;
    logic [CNT_W-1:0] r_cnt, w_ncnt;
    logic             r_en, r_sleep_req, r_wake_ack, r_gated;
    logic             w_wake_ack, w_lat_d;

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (busy_i)
                    w_ncnt = '0;
                else if (r_cnt == IDLE_LAST) begin
                    w_nstate = ST_DRAIN;
                    w_ncnt   = '0;
                end else if (r_cnt != '1)
                    w_ncnt = r_cnt + CNT_W'(1);
            end
            ST_DRAIN: begin
                if (busy_i || wake_req) begin
                    w_nstate = ST_RUN;
                    w_ncnt   = '0;
                end else if (sleep_ok_i)
                    w_nstate = ST_GATED;
            end
            ST_GATED: begin
                if (busy_i || wake_req) begin
                    w_nstate = ST_WAKE;
                    w_ncnt   = '0;
                end
            end
            ST_WAKE: begin
                w_nstate = (r_cnt == WAKE_LAST) ? ST_RUN : ST_WAKE;
                w_ncnt   = (r_cnt == WAKE_LAST) ? '0 : r_cnt + CNT_W'(1);
            end
        endcase
        w_wake_ack = (r_state == ST_RUN && wake_req) || (r_state == ST_WAKE && r_cnt == WAKE_LAST);
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_en        <= 1'b1;
            r_sleep_req <= 1'b0;
            r_wake_ack  <= 1'b0;
            r_gated     <= 1'b0;
        end else begin
            r_state     <= w_nstate;
            r_cnt       <= w_ncnt;
            r_en        <= (w_nstate != ST_GATED);
            r_sleep_req <= (w_nstate == ST_DRAIN) || (w_nstate == ST_GATED);
            r_wake_ack  <= w_wake_ack;
            r_gated     <= (w_nstate == ST_GATED);
        end
    end

`ifdef CG_TEST_EN
    assign w_lat_d = r_en | TE;
`else
    assign w_lat_d = r_en;
`endif

    cg_latch_lo u_latch (
        .i_ck  (CK),
        .i_rn  (RN),
        .i_d   (w_lat_d),
        .o_gck (GCK)
    );

    assign sleep_req_o = r_sleep_req;
    assign wake_ack    = r_wake_ack;
    assign gated_o     = r_gated;
    assign state_o     = r_state;

endmodule

// File: tb/tb_cg_ctrl_lo.sv
// tb_cg_ctrl_lo: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_cg_ctrl_lo;

    localparam int IDLE = 8;
    localparam int WAKE = 2;

    logic       CK = 1'b0, RN = 1'b0, TE = 1'b0;
    logic       busy_i = 1'b0, wake_req = 1'b0, sleep_ok_i = 1'b0;
    logic       sleep_req_o, wake_ack, gated_o, GCK;
    logic [1:0] state_o;

    int checks = 0, failures = 0;

    // Model: phase 0=run 1=drain 2=gated 3=wake; idle streak and elapsed wake cycles as plain integers.
    int   m_phase, m_idle, m_wake;
    logic m_en, m_ack;

    always #5 CK = ~CK;

    cg_ctrl_lo #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(8)) dut (
        .CK          (CK),
        .RN          (RN),
`ifdef CG_TEST_EN
        .TE          (TE),
`endif
        .busy_i      (busy_i),
        .wake_req    (wake_req),
        .sleep_ok_i  (sleep_ok_i),
        .sleep_req_o (sleep_req_o),
        .wake_ack    (wake_ack),
        .gated_o     (gated_o),
        .state_o     (state_o),
        .GCK         (GCK)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_idle  = 0;
        m_wake  = 0;
        m_en    = 1'b1;
        m_ack   = 1'b0;
    endtask

    task automatic model_edge(input logic b, input logic w, input logic s);
        m_ack = 1'b0;
        case (m_phase)
            0: begin
                m_ack  = w;
                m_idle = b ? 0 : m_idle + 1;
                if (m_idle == IDLE) begin
                    m_phase = 1;
                    m_idle  = 0;
                end
            end
            1: if (b || w) m_phase = 0; else if (s) m_phase = 2;
            2: if (b || w) begin m_phase = 3; m_wake = 0; end
            default: begin
                m_wake++;
                if (m_wake == WAKE) begin
                    m_phase = 0;
                    m_ack   = 1'b1;
                end
            end
        endcase
        m_en = (m_phase != 2);
    endtask

    task automatic check_outputs();
        chk("state", {6'd0, state_o}, 8'(m_phase));
        chk("sleep_req", {7'd0, sleep_req_o}, {7'd0, m_phase == 1 || m_phase == 2});
        chk("gated", {7'd0, gated_o}, {7'd0, m_phase == 2});
        chk("wake_ack", {7'd0, wake_ack}, {7'd0, m_ack});
        chk("gck_lo", {7'd0, GCK}, 8'd0);
    endtask

    // Called just after a falling edge; drives inputs, checks the GCK high phase and the new outputs.
    task automatic step(input logic b, input logic w, input logic s);
        logic exp_gck;
        busy_i = b; wake_req = w; sleep_ok_i = s;
        @(posedge CK);
        exp_gck = m_en | TE;
        model_edge(b, w, s);
        #2;
        chk("gck_hi", {7'd0, GCK}, {7'd0, exp_gck});
        @(negedge CK);
        check_outputs();
    endtask

    task automatic do_reset();
        RN = 1'b0; busy_i = 1'b0; wake_req = 1'b0; sleep_ok_i = 1'b0;
        @(posedge CK);
        #2;
        chk("rst_gck_hi", {7'd0, GCK}, 8'd1);
        @(negedge CK);
        model_reset();
        check_outputs();
        RN = 1'b1;
    endtask

    task automatic go_gated();
        int n = 0;
        while (!sleep_req_o && n < 40) begin step(1'b0, 1'b0, 1'b0); n++; end
        step(1'b0, 1'b0, 1'b1);
        chk("reach_gated", {6'd0, state_o}, 8'd2);
    endtask

    initial begin
        int n;
        model_reset();
        do_reset();

        // Idle latency to sleep request, then grant and first suppressed pulse.
        n = 0;
        while (!sleep_req_o && n < 20) begin step(1'b0, 1'b0, 1'b0); n++; end
        chk("idle_lat", 8'(n), 8'(IDLE));
        step(1'b0, 1'b0, 1'b1);
        chk("gated_entry", {7'd0, gated_o}, 8'd1);
        step(1'b0, 1'b0, 1'b1);

        // Wake request: GCK resumes next edge, ack after WAKE edges.
        step(1'b0, 1'b1, 1'b0);
        n = 0;
        while (!wake_ack && n < 10) begin step(1'b0, 1'b0, 1'b0); n++; end
        chk("wake_lat", 8'(n), 8'(WAKE));
        step(1'b0, 1'b0, 1'b0);
        chk("ack_one_cycle", {7'd0, wake_ack}, 8'd0);

        // Busy on idle cycle 5 restarts the idle count.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n = 0;
        while (!sleep_req_o && n < 20) begin step(1'b0, 1'b0, 1'b0); n++; end
        chk("idle_restart", 8'(n), 8'(IDLE));

        // Busy beats sleep_ok in DRAIN.
        step(1'b1, 1'b0, 1'b1);
        chk("drain_abort_state", {6'd0, state_o}, 8'd0);
        chk("drain_abort_req", {7'd0, sleep_req_o}, 8'd0);
        step(1'b1, 1'b0, 1'b0);

        // Reset asserted mid-GATED.
        go_gated();
        #2 RN = 1'b0;
        #1;
        chk("arst_state", {6'd0, state_o}, 8'd0);
        chk("arst_req", {7'd0, sleep_req_o}, 8'd0);
        chk("arst_gated", {7'd0, gated_o}, 8'd0);
        @(posedge CK);
        #2;
        chk("arst_gck", {7'd0, GCK}, 8'd1);
        @(negedge CK);
        model_reset();
        RN = 1'b1;
        check_outputs();

`ifdef CG_TEST_EN
        go_gated();
        TE = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("te_state", {6'd0, state_o}, 8'd2);
        chk("te_gated", {7'd0, gated_o}, 8'd1);
        TE = 1'b0;
        step(1'b0, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 3000; i++)
            step(($urandom % 8) == 0, ($urandom % 12) == 0, ($urandom % 3) != 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
